// File: rtl/alu_ctrl_mc.sv
// ALU control decoder with a multi-cycle multiply path.
// Non-mul ops complete in one cycle; mul holds the block busy for MUL_LAT-1 cycles.
module alu_ctrl_mc #(
    parameter int unsigned MUL_LAT    = 3,    // legal range 1..16
    parameter bit          ENABLE_MUL = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    input  logic       flush_i,
    input  logic [9:0] funct_i,
    input  logic [1:0] ALUOp_i,
    output logic [3:0] ALUCtrl_o,
    output logic       ctrl_valid_o,
    output logic       stall_o,
    output logic       illegal_o
);

    typedef enum logic {IDLE, MUL} state_t;

    localparam logic [4:0] MUL_CNT_INIT = 5'(MUL_LAT - 1);
    localparam bit         MUL_MULTI    = (MUL_LAT > 1);

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [3:0] ctrl_q, ctrl_d;
    logic       vld_q, vld_d;
    logic       ill_q, ill_d;

    logic [3:0] dec_code;
    logic       dec_illegal;
    logic       dec_mul;

    always_comb begin
        dec_code    = '0;
        dec_illegal = 1'b1;
        dec_mul     = 1'b0;
        case (ALUOp_i)
            2'b00: begin
                case (funct_i[2:0])
                    3'b000:  begin dec_code = 4'd6; dec_illegal = 1'b0; end
                    3'b101:  begin dec_code = 4'd7; dec_illegal = 1'b0; end
                    3'b010:  begin dec_code = 4'd8; dec_illegal = 1'b0; end
                    default: ;
                endcase
            end
            2'b01: begin
                if (funct_i[2:0] == 3'b000) begin
                    dec_code    = 4'd9;
                    dec_illegal = 1'b0;
                end
            end
            2'b10: begin
                case (funct_i)
                    10'b0000000111: begin dec_code = 4'd0; dec_illegal = 1'b0; end
                    10'b0000000100: begin dec_code = 4'd1; dec_illegal = 1'b0; end
                    10'b0000000001: begin dec_code = 4'd2; dec_illegal = 1'b0; end
                    10'b0000000000: begin dec_code = 4'd3; dec_illegal = 1'b0; end
                    10'b0100000000: begin dec_code = 4'd4; dec_illegal = 1'b0; end
                    10'b0000001000: begin
                        if (ENABLE_MUL) begin
                            dec_code    = 4'd5;
                            dec_illegal = 1'b0;
                            dec_mul     = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        vld_d   = 1'b0;
        ill_d   = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            ctrl_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        ctrl_d = dec_code;
                        if (dec_mul && MUL_MULTI) begin
                            state_d = MUL;
                            cnt_d   = MUL_CNT_INIT;
                        end else begin
                            vld_d = 1'b1;
                            ill_d = dec_illegal;
                        end
                    end
                end
                MUL: begin
                    // ALUCtrl stays at the mul code; result is due after the last count
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_d = IDLE;
                        vld_d   = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            vld_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            vld_q   <= vld_d;
            ill_q   <= ill_d;
        end
    end

    assign ALUCtrl_o    = ctrl_q;
    assign ctrl_valid_o = vld_q;
    assign illegal_o    = ill_q;
    assign stall_o      = (state_q == MUL);

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Scoreboard bench: several alu_ctrl_mc configurations share one stimulus stream,
// each checked against a timeline model of when its results fall due.
module tb_alu_ctrl_mc;

    localparam int NI = 6;
    localparam int unsigned LATS[NI] = '{3, 1, 2, 4, 16, 3};
    localparam bit          ENS[NI]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    localparam logic [2:0] I_F3[3]   = '{3'b000, 3'b101, 3'b010};
    localparam logic [3:0] I_CODE[3] = '{4'd6, 4'd7, 4'd8};
    localparam logic [9:0] R_F[6]    = '{10'h007, 10'h004, 10'h001, 10'h000, 10'h100, 10'h008};
    localparam logic [3:0] R_CODE[6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};

    logic       clk = 1'b0;
    logic       rst, valid, flush;
    logic [9:0] funct;
    logic [1:0] aluop;

    logic [3:0] alu_ctrl[NI];
    logic       ctrl_valid[NI];
    logic       stall[NI];
    logic       illegal[NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        alu_ctrl_mc #(.MUL_LAT(LATS[g]), .ENABLE_MUL(ENS[g])) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .valid_i     (valid),
            .flush_i     (flush),
            .funct_i     (funct),
            .ALUOp_i     (aluop),
            .ALUCtrl_o   (alu_ctrl[g]),
            .ctrl_valid_o(ctrl_valid[g]),
            .stall_o     (stall[g]),
            .illegal_o   (illegal[g])
        );
    end

    typedef struct {
        int         due;
        logic [3:0] code;
        logic       ill;
    } exp_t;

    exp_t       exp_q[NI][$];
    int         free_edge[NI];
    logic [3:0] exp_ctrl[NI];
    int         edges = 0;
    int         checks = 0;
    int         errors = 0;

    function automatic void check(string name, int inst, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s inst%0d edge%0d: got %0d expected %0d", name, inst, edges, got, want);
        end
    endfunction

    // Decode by table lookup; a mul on a build without multiply is illegal.
    function automatic void ref_dec(input logic [1:0] op, input logic [9:0] f, input bit en,
                                    output logic [3:0] code, output logic ill, output bit mul);
        code = 4'd0; ill = 1'b1; mul = 1'b0;
        if (op == 2'b00) begin
            for (int j = 0; j < 3; j++)
                if (f[2:0] == I_F3[j]) begin code = I_CODE[j]; ill = 1'b0; end
        end else if (op == 2'b01) begin
            if (f[2:0] == 3'b000) begin code = 4'd9; ill = 1'b0; end
        end else if (op == 2'b10) begin
            for (int j = 0; j < 6; j++)
                if (f == R_F[j]) begin code = R_CODE[j]; ill = 1'b0; end
        end
        if (code == 4'd5 && !ill) begin
            if (en) mul = 1'b1;
            else begin code = 4'd0; ill = 1'b1; end
        end
    endfunction

    // Advance the model by one rising edge using the inputs the DUTs just sampled.
    task automatic model_edge();
        logic [3:0] code;
        logic       ill;
        bit         mul;
        int         lat;
        edges++;
        for (int i = 0; i < NI; i++) begin
            if (rst || flush) begin
                exp_q[i].delete();
                free_edge[i] = edges + 1;
                exp_ctrl[i]  = 4'd0;
            end else if (valid && edges >= free_edge[i]) begin
                ref_dec(aluop, funct, ENS[i], code, ill, mul);
                lat = mul ? int'(LATS[i]) : 1;
                exp_q[i].push_back('{due: edges + lat - 1, code: code, ill: ill});
                free_edge[i] = edges + lat;
                exp_ctrl[i]  = code;
            end
        end
    endtask

    task automatic drive(input bit r, input bit v, input bit fl, input logic [9:0] f, input logic [1:0] op);
        @(negedge clk);
        rst = r; valid = v; flush = fl; funct = f; aluop = op;
        @(posedge clk);
        model_edge();
    endtask

    always @(negedge clk) begin
        if (edges > 0) begin
            for (int i = 0; i < NI; i++) begin
                check("stall", i, int'(stall[i]), int'(edges + 1 < free_edge[i]));
                check("alu_ctrl", i, int'(alu_ctrl[i]), int'(exp_ctrl[i]));
                if (ctrl_valid[i]) begin
                    if (exp_q[i].size() == 0) begin
                        check("spurious_valid", i, 1, 0);
                    end else begin
                        exp_t e;
                        e = exp_q[i].pop_front();
                        check("valid_timing", i, edges, e.due);
                        check("valid_code", i, int'(alu_ctrl[i]), int'(e.code));
                        check("valid_illegal", i, int'(illegal[i]), int'(e.ill));
                    end
                end else begin
                    check("illegal_without_valid", i, int'(illegal[i]), 0);
                    if (exp_q[i].size() != 0 && exp_q[i][0].due <= edges) begin
                        check("missing_valid", i, 0, 1);
                        void'(exp_q[i].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic [9:0] f;
        logic [1:0] op;
        rst = 1'b1; valid = 1'b0; flush = 1'b0; funct = '0; aluop = '0;
        for (int i = 0; i < NI; i++) begin free_edge[i] = 0; exp_ctrl[i] = 4'd0; end

        drive(1, 0, 0, 10'h000, 2'b00);
        drive(1, 1, 1, 10'h008, 2'b10);
        drive(0, 1, 0, 10'h000, 2'b01);            // first edge out of reset: beq
        drive(0, 1, 0, 10'h100, 2'b10);            // sub
        drive(0, 0, 0, 10'h000, 2'b00);
        drive(0, 1, 0, 10'h008, 2'b10);            // mul, then adds offered while busy
        drive(0, 1, 0, 10'h000, 2'b10);
        drive(0, 1, 0, 10'h000, 2'b10);
        drive(0, 1, 0, 10'h000, 2'b10);
        drive(0, 0, 0, 10'h000, 2'b00);
        drive(0, 0, 0, 10'h000, 2'b00);
        drive(0, 1, 0, 10'h3FF, 2'b11);            // illegal class
        drive(0, 1, 0, 10'h007, 2'b00);            // load class, funct3 111
        for (int i = 0; i < 16; i++) drive(0, 0, 0, 10'h000, 2'b00);
        drive(0, 1, 0, 10'h008, 2'b10);            // mul then flush with valid in 2nd stall cycle
        drive(0, 0, 0, 10'h000, 2'b00);
        drive(0, 1, 1, 10'h004, 2'b10);
        drive(0, 0, 0, 10'h000, 2'b00);
        for (int i = 0; i < 16; i++) drive(0, 0, 0, 10'h000, 2'b00);
        drive(0, 1, 0, 10'h008, 2'b10);            // reset mid-mul
        drive(0, 0, 0, 10'h000, 2'b00);
        drive(0, 0, 0, 10'h000, 2'b00);
        drive(1, 1, 1, 10'h000, 2'b10);
        drive(0, 1, 0, 10'h000, 2'b01);
        for (int i = 0; i < 17; i++) drive(0, 0, 0, 10'h000, 2'b00);
        drive(0, 1, 0, 10'h008, 2'b10);            // full-length mul on every config
        for (int i = 0; i < 17; i++) drive(0, 0, 0, 10'h000, 2'b00);

        for (int n = 0; n < 2000; n++) begin
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) < 6) f = R_F[$urandom_range(0, 5)];
            else f = 10'($urandom);
            if (op != 2'b10 && $urandom_range(0, 1) == 1) f[2:0] = I_F3[$urandom_range(0, 2)];
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 99) < 3, f, op);
        end

        for (int i = 0; i < 20; i++) drive(0, 0, 0, 10'h000, 2'b00);
        @(negedge clk);
        for (int i = 0; i < NI; i++) check("drain_empty", i, exp_q[i].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
